// File: rtl/bpu_pkg.sv
// Shared constants and types for the branch-predictor update path.
package bpu_pkg;

    // Branch type encodings as reported by the execute pipes
    localparam logic [1:0] TYPE_NO     = 2'b00;
    localparam logic [1:0] TYPE_BRANCH = 2'b01;
    localparam logic [1:0] TYPE_RET    = 2'b10;
    localparam logic [1:0] TYPE_J      = 2'b11;

    // 2-bit choice counter encodings: strong/weak local, weak/strong global
    localparam logic [1:0] SL = 2'b00;
    localparam logic [1:0] WL = 2'b01;
    localparam logic [1:0] WG = 2'b10;
    localparam logic [1:0] SG = 2'b11;

    localparam int IDX_W_DEF = 8;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] index;
        logic                 success;
    } upd_entry_t;

endpackage

// File: rtl/bpu_update_arbiter_if.sv
// Predictor-table write port: arbiter is master, table side is slave.
interface bpu_wr_if #(parameter int IDX_W = 8);
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic             wr_success;
    logic             wr_clear;

    modport master (output wr_valid, wr_index, wr_success, wr_clear, input wr_ready);
    modport slave  (input wr_valid, wr_index, wr_success, wr_clear, output wr_ready);
endinterface

// File: rtl/bpu_upd_fifo.sv
// 2-push / 1-pop circular FIFO. When both pushes fire, din0 lands at the
// tail and din1 right behind it; a lone push1 takes the tail slot.
// The caller guarantees room and never pops when empty.
module bpu_upd_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push0,
    input  logic          push1,
    input  logic [W-1:0]  din0,
    input  logic [W-1:0]  din1,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_n1;
    logic [CW-1:0]           cnt_q, cnt_d, n_push;

    assign head      = mem_q[rd_ptr_q];
    assign count     = cnt_q;
    assign wr_ptr_n1 = wr_ptr_q + PW'(1);

    // Next-state: slot writes, pointer advance, occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        n_push   = CW'(push0) + CW'(push1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push0 || push1) mem_d[wr_ptr_q]  = push0 ? din0 : din1;
            if (push0 && push1) mem_d[wr_ptr_n1] = din1;
            wr_ptr_d = wr_ptr_q + PW'(n_push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            cnt_d    = cnt_q + n_push - CW'(pop);
        end
    end

    // State registers; storage cleared so the idle head reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/bpu_update_arbiter.sv
// Serialises dual-pipe conditional-branch updates onto the single predictor
// table write port and runs full-table clear sweeps on request.
// Optional macro UPD_STATS_EN adds saturating accept/drop/clear counters.
module bpu_update_arbiter
    import bpu_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd0_valid_i,
    input  logic [1:0]        upd0_type_i,
    input  logic [ADDR_W-1:0] upd0_addr_i,
    input  logic              upd0_success_i,
    input  logic              upd1_valid_i,
    input  logic [1:0]        upd1_type_i,
    input  logic [ADDR_W-1:0] upd1_addr_i,
    input  logic              upd1_success_i,
    output logic              upd_ready_o,
    input  logic              clear_req_i,
    output logic              clear_busy_o,
    bpu_wr_if.master          wr
`ifdef UPD_STATS_EN
    ,
    output logic [31:0]       stat_accept_o,
    output logic [31:0]       stat_drop_o,
    output logic [15:0]       stat_clear_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [CW-1:0]      count;
    logic [IDX_W:0]     head, din0, din1;
    logic               br0, br1, acc0, acc1, flush, pop, sweep_done;

    assign br0  = upd0_valid_i && (upd0_type_i == TYPE_BRANCH);
    assign br1  = upd1_valid_i && (upd1_type_i == TYPE_BRANCH);
    assign din0 = {upd0_addr_i[IDX_W+2:3], upd0_success_i};
    assign din1 = {upd1_addr_i[IDX_W+2:3], upd1_success_i};

    // Arbitration, write-port drive and RUN/CLEAR sequencing
    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        flush         = 1'b0;
        sweep_done    = 1'b0;
        // pop is not credited here: readiness only looks at registered count
        upd_ready_o   = (state_q == RUN) && (int'(count) <= DEPTH - 2);
        acc0          = br0 && upd_ready_o && !clear_req_i;
        acc1          = br1 && upd_ready_o && !clear_req_i;
        clear_busy_o  = (state_q == CLEAR);
        wr.wr_valid   = (count != '0);
        wr.wr_index   = head[IDX_W:1];
        wr.wr_success = head[0];
        wr.wr_clear   = 1'b0;
        if (state_q == RUN) begin
            if (clear_req_i) begin
                state_d = CLEAR;
                sweep_d = '0;
                flush   = 1'b1;
            end
        end else begin
            wr.wr_valid   = 1'b1;
            wr.wr_index   = sweep_q;
            wr.wr_success = 1'b0;
            wr.wr_clear   = 1'b1;
            if (clear_req_i) begin
                sweep_d = '0;
            end else if (wr.wr_ready) begin
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == {IDX_W{1'b1}}) begin
                    state_d    = RUN;
                    sweep_done = 1'b1;
                end
            end
        end
        pop = (state_q == RUN) && wr.wr_valid && wr.wr_ready;
    end

    // FSM state and sweep pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    bpu_upd_fifo #(.W(IDX_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push0 (acc0),
        .push1 (acc1),
        .din0  (din0),
        .din1  (din1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    logic unused_ok;
    assign unused_ok = ^{upd0_addr_i[ADDR_W-1:IDX_W+3], upd0_addr_i[2:0],
                         upd1_addr_i[ADDR_W-1:IDX_W+3], upd1_addr_i[2:0]};

`ifdef UPD_STATS_EN
    logic [31:0] acc_cnt_q, acc_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [15:0] clr_cnt_q, clr_cnt_d;
    logic [32:0] acc_sum, drop_sum;
    logic [16:0] clr_sum;

    // Saturating statistics; drops are type-01 updates refused for any reason
    always_comb begin
        acc_sum    = {1'b0, acc_cnt_q} + 33'(acc0) + 33'(acc1);
        drop_sum   = {1'b0, drop_cnt_q} + 33'(br0 && !acc0) + 33'(br1 && !acc1);
        clr_sum    = {1'b0, clr_cnt_q} + 17'(sweep_done);
        acc_cnt_d  = acc_sum[32]  ? '1 : acc_sum[31:0];
        drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
        clr_cnt_d  = clr_sum[16]  ? '1 : clr_sum[15:0];
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q  <= '0;
            drop_cnt_q <= '0;
            clr_cnt_q  <= '0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    assign stat_accept_o = acc_cnt_q;
    assign stat_drop_o   = drop_cnt_q;
    assign stat_clear_o  = clr_cnt_q;
`endif
endmodule
